// File: rtl/slave_mem_ctrl_pkg.sv
// Shared constants and FSM encoding for the
// request-queued slave memory controller.
package cb_pkg;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/slave_mem_ctrl_if.sv
// Request/response bundle between a bus master
// and the slave memory controller.
interface slave_mem_ctrl_if
    import cb_pkg::*;
#(
    parameter int N  = 31,
    parameter int LW = lvl_w(4)
);

    logic          req;
    logic [N:0]    addr;
    logic          cmd;
    logic [N:0]    wdata;
    logic          ack;
    logic [N:0]    rdata;
    logic          err_ovf;
    logic [LW-1:0] fifo_level;

    modport master (
        output req, addr, cmd, wdata,
        input  ack, rdata, err_ovf, fifo_level
    );

    modport slave (
        input  req, addr, cmd, wdata,
        output ack, rdata, err_ovf, fifo_level
    );

endinterface

// File: rtl/slave_mem_ctrl_fifo.sv
// Synchronous request queue with occupancy count;
// a push into a full queue is taken only alongside a pop.
module req_fifo
    import cb_pkg::*;
#(
    parameter int W     = 41,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int LW   = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    // Power-of-two depth lets the pointers wrap by overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/slave_mem_ctrl.sv
// Queued slave memory: requests wait LATENCY cycles,
// then complete with a one-cycle ack.
module slave_mem_ctrl
    import cb_pkg::*;
#(
    parameter int N          = 31,
    parameter int AW         = 8,
    parameter int LATENCY    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input logic             clk,
    input logic             reset,
    slave_mem_ctrl_if.slave bus
);

    localparam int LW = lvl_w(FIFO_DEPTH);

    typedef struct packed {
        logic [AW-1:0] a;
        logic          c;
        logic [N:0]    d;
    } ent_t;

    state_t         state;
    state_t         state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    ent_t           cur;
    ent_t           head;
    ent_t           ent_in;
    logic           pop;
    logic           full;
    logic           empty;
    logic [LW-1:0]  level;
    logic           err_q;
    logic [N:0]     rdata_q;
    logic [N:0]     mem [2**AW];
    logic           unused_addr;

    assign unused_addr = ^bus.addr[N:AW];

    assign ent_in = '{a: bus.addr[AW-1:0],
                      c: bus.cmd,
                      d: bus.wdata};

    req_fifo #(
        .W     ($bits(ent_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (bus.req),
        .pop   (pop),
        .din   (ent_in),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pop     = 1'b0;
        unique case (state)
            IDLE: pop = !empty;
            WAIT: begin
                cnt_n = cnt - 1'b1;
                if (cnt == CNT_W'(1))
                    state_n = ACK;
            end
            ACK: begin
                state_n = IDLE;
                pop     = !empty;
            end
            default: state_n = IDLE;
        endcase
        // Any pop starts the next transaction's wait.
        if (pop) begin
            cnt_n   = CNT_W'(LATENCY);
            state_n = (LATENCY == 0) ? ACK : WAIT;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            cur   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (pop)
                cur <= head;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (bus.req && full && !pop)
                err_q <= 1'b1;
            if (state == ACK && cur.c == CMD_READ)
                rdata_q <= mem[cur.a];
        end
    end

    always_ff @(posedge clk) begin
        if (state == ACK && cur.c == CMD_WRITE)
            mem[cur.a] <= cur.d;
    end

    assign bus.ack        = (state == ACK);
    assign bus.rdata      = rdata_q;
    assign bus.err_ovf    = err_q;
    assign bus.fifo_level = level;

endmodule
